aes_dec_host_ctrl: RTL and testbench

- Host-side initiator for the AES inverse-cipher core port set (ld, kld, key, text_in, text_out, done, kdone).
- Accepts a 128-bit key and a stream of 128-bit ciphertext blocks over valid/ready.
- Sequences key expansion (kld/kdone), then one decrypt per block (ld/done), and returns each plaintext over valid/ready.
- Sits between the bus/testbench stimulus layer and the instantiated inverse cipher, and adds timeout detection.

---
 rtl/aes_dec_host_ctrl.sv | 128 ++++++++++++
 tb/tb_aes_dec_host_ctrl.sv | 566 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_dec_host_ctrl.sv
// Host-side sequencer for an AES inverse-cipher core: loads a key, runs one decrypt
// per accepted ciphertext block, returns plaintext over valid/ready, watches for core timeouts.
module aes_dec_host_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         key_valid,
   input  logic [127:0] key_in,
   output logic         key_ready,
   input  logic         s_valid,
   input  logic [127:0] s_data,
   output logic         s_ready,
   output logic         m_valid,
   output logic [127:0] m_data,
   input  logic         m_ready,
   output logic         busy,
   output logic         err,
   input  logic         err_clr,
   output logic         c_kld,
   output logic         c_ld,
   output logic [127:0] c_key,
   output logic [127:0] c_text_in,
   input  logic [127:0] c_text_out,
   input  logic         c_kdone,
   input  logic         c_done
);
   localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {IDLE, KLOAD, KWAIT, DLOAD, DWAIT, HOLD} state_t;

   state_t           state, state_nxt;
   logic             key_loaded;
   logic [CNT_W-1:0] tmo_cnt;
   logic             key_take, blk_take, tmo_hit;

   // NOTE: every signal driven here gets a default first so no path infers a latch.
   always_comb begin
      state_nxt = state;
      key_ready = 1'b0;
      s_ready   = 1'b0;
      c_kld     = 1'b0;
      c_ld      = 1'b0;
      m_valid   = 1'b0;
      key_take  = 1'b0;
      blk_take  = 1'b0;
      tmo_hit   = 1'b0;
      unique case (state)
         IDLE: begin
            key_ready = !rst;
            // A pending key always wins over data.
            s_ready   = !rst && key_loaded && !key_valid;
            key_take  = key_valid && key_ready;
            blk_take  = s_valid && s_ready;
            if (key_take)      state_nxt = KLOAD;
            else if (blk_take) state_nxt = DLOAD;
         end
         KLOAD: begin
            c_kld     = 1'b1;
            state_nxt = KWAIT;
         end
         KWAIT: begin
            if (c_kdone) begin
               state_nxt = IDLE;
            end else if (tmo_cnt == CNT_LAST) begin
               tmo_hit   = 1'b1;
               state_nxt = IDLE;
            end
         end
         DLOAD: begin
            c_ld      = 1'b1;
            state_nxt = DWAIT;
         end
         DWAIT: begin
            // Completion in the final allowed cycle still beats the timeout.
            if (c_done) begin
               state_nxt = HOLD;
            end else if (tmo_cnt == CNT_LAST) begin
               tmo_hit   = 1'b1;
               state_nxt = IDLE;
            end
         end
         HOLD: begin
            m_valid = 1'b1;
            if (m_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   // NOTE: synchronous reset, and every register uses non-blocking assignment so all
   // updates see pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         key_loaded <= 1'b0;
         tmo_cnt    <= '0;
         err        <= 1'b0;
         c_key      <= '0;
         c_text_in  <= '0;
         m_data     <= '0;
      end else begin
         state <= state_nxt;

         if (key_take) begin
            c_key      <= key_in;
            key_loaded <= 1'b0;
         end else if (state == KWAIT && c_kdone) begin
            key_loaded <= 1'b1;
         end

         if (blk_take) c_text_in <= s_data;

         if (state == DWAIT && c_done) m_data <= c_text_out;

         // The load states precede each wait state, so clearing there clears on entry.
         if (state == KLOAD || state == DLOAD)      tmo_cnt <= '0;
         else if (state == KWAIT || state == DWAIT) tmo_cnt <= tmo_cnt + 1'b1;

         if (tmo_hit)      err <= 1'b1;
         else if (err_clr) err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_aes_dec_host_ctrl.sv
// Bench for aes_dec_host_ctrl: behavioural inverse-cipher core (real AES, xor stand-in,
// or mute), plaintext scoreboard, and one task per scenario.
module tb_aes_dec_host_ctrl;
   localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         key_valid = 1'b0;
   logic [127:0] key_in = '0;
   logic         key_ready;
   logic         s_valid = 1'b0;
   logic [127:0] s_data = '0;
   logic         s_ready;
   logic         m_valid;
   logic [127:0] m_data;
   logic         m_ready = 1'b0;
   logic         busy;
   logic         err;
   logic         err_clr = 1'b0;
   logic         c_kld;
   logic         c_ld;
   logic [127:0] c_key;
   logic [127:0] c_text_in;
   logic [127:0] c_text_out;
   logic         c_kdone;
   logic         c_done;

   aes_dec_host_ctrl #(.TIMEOUT_CYC(64)) dut (
      .clk(clk), .rst(rst),
      .key_valid(key_valid), .key_in(key_in), .key_ready(key_ready),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
      .busy(busy), .err(err), .err_clr(err_clr),
      .c_kld(c_kld), .c_ld(c_ld), .c_key(c_key), .c_text_in(c_text_in),
      .c_text_out(c_text_out), .c_kdone(c_kdone), .c_done(c_done)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   logic [127:0] exp_q[$];

   // ---------------- behavioural core ----------------
   typedef enum int {CORE_AES, CORE_XOR, CORE_MUTE} core_mode_t;
   core_mode_t   core_mode = CORE_XOR;
   int unsigned  klat = 12;
   int unsigned  dlat = 10;
   int unsigned  kcnt = 0;
   int unsigned  dcnt = 0;
   int unsigned  ld_count = 0;
   logic [127:0] core_key = '0;
   logic [127:0] dbuf = '0;
   logic [127:0] out_r = '0;
   logic         kdone_r = 1'b0;
   logic         done_r = 1'b0;
   logic         inj_done = 1'b0;
   logic         inj_kdone = 1'b0;
   logic [127:0] inj_data = '0;
   logic [7:0]   sbox_t[256];
   logic [7:0]   inv_t[256];

   assign c_kdone    = kdone_r | inj_kdone;
   assign c_done     = done_r | inj_done;
   assign c_text_out = inj_done ? inj_data : out_r;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   task automatic build_tables();
      logic [7:0] y;
      logic [7:0] s;
      for (int v = 0; v < 256; v++) begin
         y = 8'h01;
         for (int i = 0; i < 254; i++) y = gmul(y, 8'(v));
         s = y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
         sbox_t[v] = s;
         inv_t[s]  = 8'(v);
      end
   endtask

   function automatic logic [127:0] aes_inv(input logic [127:0] ct, input logic [127:0] key);
      logic [31:0]  w[44];
      logic [127:0] rk[11];
      logic [7:0]   rcon = 8'h01;
      logic [31:0]  t;
      logic [127:0] s;
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rcon, 24'h0};
            rcon = gmul(rcon, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      s = ct ^ rk[10];
      for (int r = 9; r >= 0; r--) begin
         for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
               o[127-8*(rr+4*c) -: 8] = inv_t[s[127-8*(rr+4*((c-rr+4)%4)) -: 8]];
         s = o ^ rk[r];
         if (r != 0) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[127-8*(4*c)   -: 8];
               a1 = s[127-8*(4*c+1) -: 8];
               a2 = s[127-8*(4*c+2) -: 8];
               a3 = s[127-8*(4*c+3) -: 8];
               s[127-8*(4*c)   -: 8] = gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09);
               s[127-8*(4*c+1) -: 8] = gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d);
               s[127-8*(4*c+2) -: 8] = gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b);
               s[127-8*(4*c+3) -: 8] = gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e);
            end
         end
      end
      return s;
   endfunction

   // Core has no reset: completions still in flight after a host reset arrive late.
   always @(posedge clk) begin
      kdone_r <= 1'b0;
      done_r  <= 1'b0;
      if (c_kld) begin
         core_key <= c_key;
         kcnt     <= klat;
      end else if (kcnt != 0) begin
         kcnt <= kcnt - 1;
         if (kcnt == 1 && core_mode != CORE_MUTE) kdone_r <= 1'b1;
      end
      if (c_ld) begin
         ld_count <= ld_count + 1;
         dcnt     <= dlat;
         dbuf     <= (core_mode == CORE_AES) ? aes_inv(c_text_in, core_key) : (c_text_in ^ core_key);
      end else if (dcnt != 0) begin
         dcnt <= dcnt - 1;
         if (dcnt == 1 && core_mode != CORE_MUTE) begin
            done_r <= 1'b1;
            out_r  <= dbuf;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic send_key(input logic [127:0] k, input string name);
      bit ok = 1'b0;
      key_valid = 1'b1;
      key_in    = k;
      for (int n = 0; n < 200 && !ok; n++) begin
         #1;
         ok = key_ready;
         step();
      end
      key_valid = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: key_ready never rose within 200 cycles", name);
      end
   endtask

   // Returns one cycle after the handshake edge, where c_ld must already be high.
   task automatic send_block(input logic [127:0] ct, input string name);
      bit ok = 1'b0;
      s_valid = 1'b1;
      s_data  = ct;
      for (int n = 0; n < 200 && !ok; n++) begin
         #1;
         ok = s_ready;
         step();
      end
      s_valid = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: s_ready never rose within 200 cycles", name);
      end else if (c_ld !== 1'b1 || c_text_in !== ct) begin
         errors++;
         $display("FAIL %s: c_ld=%b c_text_in=%h, required c_ld=1 c_text_in=%h", name, c_ld, c_text_in, ct);
      end
   endtask

   task automatic recv_block(input string name, input int bound);
      logic [127:0] exp;
      bit got = 1'b0;
      m_ready = 1'b1;
      for (int n = 0; n < bound && !got; n++) begin
         #1;
         if (m_valid === 1'b1) begin
            got = 1'b1;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL %s: m_valid with m_data=%h, required no output", name, m_data);
            end else begin
               exp = exp_q.pop_front();
               if (m_data !== exp) begin
                  errors++;
                  $display("FAIL %s: m_data=%h, required %h", name, m_data, exp);
               end
            end
         end
         step();
      end
      m_ready = 1'b0;
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL %s: no m_valid within %0d cycles", name, bound);
      end
   endtask

   task automatic wait_kdone(input string name);
      bit seen = 1'b0;
      for (int n = 0; n < 60 && !seen; n++) begin
         #1;
         seen = c_kdone;
         step();
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s: c_kdone never seen within 60 cycles", name);
      end
   endtask

   task automatic check_all_zero(input string name);
      checks++;
      if ({m_valid, c_kld, c_ld, err, busy, key_ready, s_ready} !== 7'b0 ||
          m_data !== '0 || c_key !== '0 || c_text_in !== '0) begin
         errors++;
         $display("FAIL %s: m_valid=%b c_kld=%b c_ld=%b err=%b busy=%b key_ready=%b s_ready=%b m_data=%h c_key=%h c_text_in=%h, required all 0",
                  name, m_valid, c_kld, c_ld, err, busy, key_ready, s_ready, m_data, c_key, c_text_in);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      check_all_zero("reset_outputs");
      rst = 1'b0;
      #1;
      checks++;
      if (key_ready !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: key_ready=%b s_ready=%b busy=%b, required 1 0 0", key_ready, s_ready, busy);
      end
      step();
   endtask

   task automatic test_key_load();
      bit bad = 1'b0;
      bit seen = 1'b0;
      core_mode = CORE_XOR;
      klat      = 12;
      send_key(KEY1, "kl_handshake");
      checks++;
      if (c_kld !== 1'b1 || c_key !== KEY1) begin
         errors++;
         $display("FAIL kl_pulse: c_kld=%b c_key=%h, required 1 %h", c_kld, c_key, KEY1);
      end
      step();
      checks++;
      if (c_kld !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL kl_pulse_width: c_kld=%b busy=%b, required 0 1", c_kld, busy);
      end
      for (int n = 0; n < 60 && !seen; n++) begin
         #1;
         seen = c_kdone;
         if (s_ready !== 1'b0) bad = 1'b1;
         step();
      end
      checks++;
      if (!seen || bad) begin
         errors++;
         $display("FAIL kl_wait: kdone_seen=%b s_ready_leak=%b, required 1 0", seen, bad);
      end
      checks++;
      if (s_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL kl_ready_after_kdone: s_ready=%b busy=%b, required 1 0", s_ready, busy);
      end
   endtask

   task automatic test_fips();
      int unsigned ld0;
      core_mode = CORE_AES;
      dlat      = 10;
      ld0       = ld_count;
      exp_q.push_back(FIPS_PT);
      send_block(FIPS_CT, "fips_ld");
      recv_block("fips_pt", 100);
      step();
      checks++;
      if (ld_count - ld0 !== 1) begin
         errors++;
         $display("FAIL fips_ld_count: c_ld pulses=%0d, required 1", ld_count - ld0);
      end
   endtask

   task automatic test_backpressure();
      logic [127:0] ct1 = rnd128();
      logic [127:0] ct2 = rnd128();
      logic [127:0] held;
      bit ok = 1'b0;
      bit stable = 1'b1;
      core_mode = CORE_XOR;
      dlat      = 5;
      exp_q.push_back(ct1 ^ KEY1);
      send_block(ct1, "bp_ld");
      for (int n = 0; n < 50 && !ok; n++) begin
         #1;
         ok = m_valid;
         if (!ok) step();
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL bp_valid: m_valid never rose within 50 cycles");
      end
      held    = m_data;
      s_valid = 1'b1;
      s_data  = ct2;
      for (int n = 0; n < 20; n++) begin
         #1;
         if (m_valid !== 1'b1 || m_data !== held || s_ready !== 1'b0) stable = 1'b0;
         step();
      end
      checks++;
      if (!stable) begin
         errors++;
         $display("FAIL bp_hold: m_valid/m_data/s_ready changed under backpressure, m_data=%h required %h", m_data, held);
      end
      exp_q.push_back(ct2 ^ KEY1);
      recv_block("bp_pt1", 5);
      #1;
      checks++;
      if (busy !== 1'b0 || s_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_idle: busy=%b s_ready=%b, required 0 1", busy, s_ready);
      end
      step();
      s_valid = 1'b0;
      checks++;
      if (c_ld !== 1'b1 || c_text_in !== ct2) begin
         errors++;
         $display("FAIL bp_next_accept: c_ld=%b c_text_in=%h, required 1 %h", c_ld, c_text_in, ct2);
      end
      recv_block("bp_pt2", 50);
   endtask

   task automatic test_key_priority();
      logic [127:0] ct = rnd128();
      bit seen = 1'b0;
      bit leak = 1'b0;
      core_mode = CORE_XOR;
      dlat      = 7;
      exp_q.push_back(ct ^ KEY2);
      key_valid = 1'b1;
      key_in    = KEY2;
      s_valid   = 1'b1;
      s_data    = ct;
      #1;
      checks++;
      if (key_ready !== 1'b1 || s_ready !== 1'b0) begin
         errors++;
         $display("FAIL prio_select: key_ready=%b s_ready=%b, required 1 0", key_ready, s_ready);
      end
      step();
      key_valid = 1'b0;
      checks++;
      if (c_kld !== 1'b1 || c_key !== KEY2) begin
         errors++;
         $display("FAIL prio_key_taken: c_kld=%b c_key=%h, required 1 %h", c_kld, c_key, KEY2);
      end
      for (int n = 0; n < 60 && !seen; n++) begin
         #1;
         seen = c_kdone;
         if (s_ready !== 1'b0) leak = 1'b1;
         step();
      end
      checks++;
      if (!seen || leak) begin
         errors++;
         $display("FAIL prio_wait: kdone_seen=%b s_ready_leak=%b, required 1 0", seen, leak);
      end
      #1;
      step();
      s_valid = 1'b0;
      checks++;
      if (c_ld !== 1'b1 || c_text_in !== ct) begin
         errors++;
         $display("FAIL prio_block_after_key: c_ld=%b c_text_in=%h, required 1 %h", c_ld, c_text_in, ct);
      end
      recv_block("prio_pt", 50);
   endtask

   task automatic test_timeout();
      logic [127:0] md;
      bit bad = 1'b0;
      core_mode = CORE_MUTE;
      dlat      = 10;
      send_block(rnd128(), "tmo_ld");
      for (int n = 0; n < 64; n++) begin
         step();
         if (err !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b1) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL tmo_early: err/m_valid/busy wrong inside the 64 DWAIT cycles, err=%b busy=%b", err, busy);
      end
      step();
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
         errors++;
         $display("FAIL tmo_fire: err=%b busy=%b m_valid=%b, required 1 0 0", err, busy, m_valid);
      end
      step();
      step();
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL tmo_clear: err=%b, required 0", err);
      end
      md       = m_data;
      inj_data = rnd128();
      inj_done = 1'b1;
      step();
      inj_done = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || m_valid !== 1'b0 || m_data !== md || s_ready !== 1'b1) begin
         errors++;
         $display("FAIL tmo_late_done: busy=%b m_valid=%b m_data=%h s_ready=%b, required 0 0 %h 1",
                  busy, m_valid, m_data, s_ready, md);
      end
      step();
   endtask

   task automatic test_timeout_boundary();
      logic [127:0] ct = rnd128();
      core_mode = CORE_XOR;
      dlat      = 63;
      exp_q.push_back(ct ^ KEY2);
      send_block(ct, "edge_ld");
      recv_block("edge_done_wins", 100);
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL edge_no_err: err=%b, required 0", err);
      end
      dlat    = 64;
      send_block(rnd128(), "edge_late_ld");
      err_clr = 1'b1;
      repeat (65) step();
      err_clr = 1'b0;
      checks++;
      if (err !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL edge_set_beats_clr: err=%b busy=%b, required 1 0", err, busy);
      end
      repeat (3) step();
      checks++;
      if (m_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL edge_late_ignored: m_valid=%b busy=%b, required 0 0", m_valid, busy);
      end
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
   endtask

   task automatic test_reset_mid_dwait();
      logic [127:0] ct = rnd128();
      bit bad = 1'b0;
      core_mode = CORE_XOR;
      dlat      = 30;
      send_block(ct, "rst_ld");
      repeat (5) step();
      rst = 1'b1;
      step();
      check_all_zero("rst_mid_outputs");
      rst     = 1'b0;
      s_valid = 1'b1;
      s_data  = ct;
      for (int n = 0; n < 40; n++) begin
         inj_kdone = (n == 10);
         #1;
         if (s_ready !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
         step();
      end
      inj_kdone = 1'b0;
      s_valid   = 1'b0;
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL rst_no_key: s_ready/m_valid/busy rose before a new key, s_ready=%b m_valid=%b busy=%b",
                  s_ready, m_valid, busy);
      end
      send_key(KEY1, "rst_rekey");
      wait_kdone("rst_rekey_done");
      checks++;
      if (s_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_ready_after_key: s_ready=%b, required 1", s_ready);
      end
      dlat = 4;
      exp_q.push_back(ct ^ KEY1);
      send_block(ct, "rst_resume_ld");
      recv_block("rst_resume_pt", 50);
   endtask

   initial begin
      build_tables();
      test_reset();
      test_key_load();
      test_fips();
      test_backpressure();
      test_key_priority();
      test_timeout();
      test_timeout_boundary();
      test_reset_mid_dwait();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d blocks outstanding, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
